id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage feeding alu_design in the RV32I core. Accepts one instruction per
//  valid/ready handshake, decodes OP/OP-IMM/LUI/AUIPC into the 4-bit ALU select, and picks
//  ALU operands with EX/WB forwarding. Registers everything for the EX cycle, with stall
//  (backpressure) and flush. ALU-side outputs connect straight to A, B and Data_sel.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  RESET_PC  0   value of pc_q after reset
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   upstream holds a valid instruction
//  in_ready    out  1   stage can accept this cycle
//  instr       in   32  raw instruction word
//  pc          in   32  PC of instr
//  rs1_data    in   32  register-file read for instr[19:15]
//  rs2_data    in   32  register-file read for instr[24:20]
//  ex_wen      in   1   instruction now in EX writes rd
//  ex_rd       in   5   EX destination register
//  ex_result   in   32  EX ALU result
//  wb_wen      in   1   instruction now in WB writes rd
//  wb_rd       in   5   WB destination register
//  wb_result   in   32  WB write data
//  flush       in   1   kill the held and incoming instruction
//  out_valid   out  1   registered bundle is valid
//  out_ready   in   1   downstream consumes the bundle this cycle
//  alu_a       out  32  operand A -> alu_design.A
//  alu_b       out  32  operand B -> alu_design.B
//  alu_sel     out  4   -> alu_design.Data_sel
//  rd_q        out  5   destination register
//  reg_wen_q   out  1   writeback enable
//  pc_q        out  32  PC of the held instruction
//  illegal_q   out  1   opcode is outside the supported set
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, alu_a=alu_b=0, alu_sel=4'b0000, rd_q=0, reg_wen_q=0.
//   - pc_q=RESET_PC, illegal_q=0.
//  Handshake:
//   - in_ready = !out_valid | out_ready (combinational).
//   - Capture happens on in_valid & in_ready. Latency is 1 cycle.
//   - While out_valid & !out_ready, every output holds stable.
//   - If out_ready=1 and in_valid=0, out_valid clears next cycle.
//  Flush:
//   - Next cycle out_valid=0 and reg_wen_q=0, whatever in_valid is.
//   - Flush has priority over capture. The data registers may keep stale values.
//  Decode (opc=instr[6:0], f3=instr[14:12], f7b=instr[30]):
//   - OP 0110011: f3 000 -> add (0000), or sub (0001) if f7b=1; 111 and 0010; 110 or 0011;
//     100 xor 0100; 001 sll 0101; 101 srl 0110, or sra 1001 if f7b=1; 010 slt 0111;
//     011 sltu 1000. B=rs2.
//   - OP-IMM 0010011: same map with B=sext(instr[31:20]); f7b selects only srai vs srli.
//     For f3=000, f7b is ignored (addi, never sub). Shifts use B=zext(instr[24:20]).
//   - LUI 0110111: A={instr[31:12],12'b0}, B=0, sel=1111 (ALU passes A).
//   - AUIPC 0010111: A=pc, B={instr[31:12],12'b0}, sel=0000.
//   - Any other opc: illegal_q=1, reg_wen_q=0, sel=0000, A=B=0.
//   - rd_q=instr[11:7]. reg_wen_q=1 for the four legal opcodes when rd!=0; x0 is never written.
//  Forwarding (evaluated at capture, per operand that uses a register):
//   - Priority: EX, then WB, then register file.
//   - Match requires wen=1, rd!=0 and rd equal to the source register.
//   - A source register of x0 always yields 0.
// TESTING
//  1. rst_n=0 mid-stream with out_valid=1 -> all outputs reach reset values immediately, without a clock edge.
//  2. add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, no forwards -> next cycle alu_a=5, alu_b=7, sel=0000, rd_q=3, wen=1.
//  3. sub x3,x1,x2 with ex_wen=1,ex_rd=1,ex_result=100 and wb_wen=1,wb_rd=1,wb_result=9 -> alu_a=100 (EX wins), sel=0001.
//  4. srai x5,x6,4 (0x40435293) -> alu_b=4, sel=1001.
//     addi x5,x0,-1 (0xFFF00293) with ex_rd=0,ex_wen=1 -> alu_a=0, alu_b=0xFFFFFFFF.
//  5. Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen.
//     Then out_ready=1 -> the next instruction is captured; no loss, no duplicate.
//  6. flush=1 in the same cycle as in_valid=1 -> out_valid=0 next cycle.
//     LUI x1,0x12345 -> alu_a=0x12345000, sel=1111.
//     Opcode 0x7F -> illegal_q=1, wen=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes OP/OP-IMM/LUI/AUIPC into an ALU select, resolves
// operands with EX/WB forwarding and holds the result for EX under valid/ready flow control.
module id_ex_stage #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_wen,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  output logic [4:0]      rd_q,
  output logic            reg_wen_q,
  output logic [XLEN-1:0] pc_q,
  output logic            illegal_q
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]      opc_d;
  logic [2:0]      f3_d;
  logic            f7b_d;
  logic [4:0]      rs1_idx_d;
  logic [4:0]      rs2_idx_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic [3:0]      sel_d;
  logic            wen_d;
  logic            ill_d;
  logic            capture_d;

  // Youngest producer wins; x0 is hard-wired to zero regardless of any pending write.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [4:0]      src,
    input logic [XLEN-1:0] rf_val,
    input logic            exw,
    input logic [4:0]      exr,
    input logic [XLEN-1:0] exv,
    input logic            wbw,
    input logic [4:0]      wbr,
    input logic [XLEN-1:0] wbv
  );
    logic [XLEN-1:0] val;
    if (src == 5'd0) begin
      val = {XLEN{1'b0}};
    end else if (exw && (exr != 5'd0) && (exr == src)) begin
      val = exv;
    end else if (wbw && (wbr != 5'd0) && (wbr == src)) begin
      val = wbv;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b, input logic is_reg);
    logic [3:0] sel;
    case (f3)
      3'b000:  sel = (is_reg && f7b) ? 4'b0001 : 4'b0000;
      3'b111:  sel = 4'b0010;
      3'b110:  sel = 4'b0011;
      3'b100:  sel = 4'b0100;
      3'b001:  sel = 4'b0101;
      3'b101:  sel = f7b ? 4'b1001 : 4'b0110;
      3'b010:  sel = 4'b0111;
      3'b011:  sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign capture_d = in_valid && in_ready;

  assign opc_d     = instr[6:0];
  assign f3_d      = instr[14:12];
  assign f7b_d     = instr[30];
  assign rs1_idx_d = instr[19:15];
  assign rs2_idx_d = instr[24:20];
  assign rd_d      = instr[11:7];

  // Decode the incoming instruction into the bundle captured on the next edge.
  always_comb begin
    a_d   = {XLEN{1'b0}};
    b_d   = {XLEN{1'b0}};
    sel_d = 4'b0000;
    wen_d = 1'b0;
    ill_d = 1'b0;
    case (opc_d)
      OPC_OP, OPC_OP_IMM: begin
        a_d   = fwd_operand(rs1_idx_d, rs1_data, ex_wen, ex_rd, ex_result, wb_wen, wb_rd, wb_result);
        sel_d = alu_op(f3_d, f7b_d, opc_d == OPC_OP);
        wen_d = (rd_d != 5'd0);
        if (opc_d == OPC_OP) begin
          b_d = fwd_operand(rs2_idx_d, rs2_data, ex_wen, ex_rd, ex_result, wb_wen, wb_rd, wb_result);
        end else if ((f3_d == 3'b001) || (f3_d == 3'b101)) begin
          b_d = {27'd0, instr[24:20]};
        end else begin
          b_d = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI: begin
        a_d   = {instr[31:12], 12'd0};
        sel_d = 4'b1111;
        wen_d = (rd_d != 5'd0);
      end
      OPC_AUIPC: begin
        a_d   = pc;
        b_d   = {instr[31:12], 12'd0};
        wen_d = (rd_d != 5'd0);
      end
      default: begin
        ill_d = 1'b1;
      end
    endcase
  end

  // Output bundle: flush beats capture, capture beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= {XLEN{1'b0}};
      alu_b     <= {XLEN{1'b0}};
      alu_sel   <= 4'b0000;
      rd_q      <= 5'd0;
      reg_wen_q <= 1'b0;
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_wen_q <= 1'b0;
    end else if (capture_d) begin
      out_valid <= 1'b1;
      alu_a     <= a_d;
      alu_b     <= b_d;
      alu_sel   <= sel_d;
      rd_q      <= rd_d;
      reg_wen_q <= wen_d;
      pc_q      <= pc;
      illegal_q <= ill_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cases then randomized traffic against a
// behavioural decode/forwarding model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] instr, pc, rs1_data, rs2_data, ex_result, wb_result;
  logic        ex_wen, wb_wen;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] alu_a, alu_b, pc_q;
  logic [3:0]  alu_sel;
  logic [4:0]  rd_q;
  logic        reg_wen_q, illegal_q;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .rd_q(rd_q),
    .reg_wen_q(reg_wen_q), .pc_q(pc_q), .illegal_q(illegal_q)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
    logic [31:0] pc;
  } bund_t;

  bund_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  exp_valid = 1'b0;
  logic  last_flush = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input bund_t e);
    chk({tag, ".alu_a"}, alu_a, e.a);
    chk({tag, ".alu_b"}, alu_b, e.b);
    chk({tag, ".alu_sel"}, {28'd0, alu_sel}, {28'd0, e.sel});
    chk({tag, ".rd_q"}, {27'd0, rd_q}, {27'd0, e.rd});
    chk({tag, ".reg_wen_q"}, {31'd0, reg_wen_q}, {31'd0, e.wen});
    chk({tag, ".illegal_q"}, {31'd0, illegal_q}, {31'd0, e.ill});
    chk({tag, ".pc_q"}, pc_q, e.pc);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] sel, input logic [4:0] rd, input logic wen, input logic ill);
    chk({nm, ".alu_a"}, alu_a, a);
    chk({nm, ".alu_b"}, alu_b, b);
    chk({nm, ".alu_sel"}, {28'd0, alu_sel}, {28'd0, sel});
    chk({nm, ".rd_q"}, {27'd0, rd_q}, {27'd0, rd});
    chk({nm, ".reg_wen_q"}, {31'd0, reg_wen_q}, {31'd0, wen});
    chk({nm, ".illegal_q"}, {31'd0, illegal_q}, {31'd0, ill});
  endtask

  // Value a source register should deliver: x0, then newest in-flight writer, then register file.
  function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf,
      input logic exw, input logic [4:0] exr, input logic [31:0] exv,
      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbv);
    if (r == 5'd0) return 32'd0;
    if (exw && exr == r) return exv;
    if (wbw && wbr == r) return wbv;
    return rf;
  endfunction

  function automatic bund_t model(input logic [31:0] ins, input logic [31:0] p,
      input logic [31:0] r1, input logic [31:0] r2,
      input logic exw, input logic [4:0] exr, input logic [31:0] exv,
      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbv);
    bund_t      m;
    logic [3:0] tbl [8];
    logic [6:0] opc;
    logic [2:0] f3;
    tbl = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
    opc = ins[6:0];
    f3  = ins[14:12];
    m.pc = p; m.rd = ins[11:7];
    m.a = 32'd0; m.b = 32'd0; m.sel = 4'd0; m.wen = 1'b0; m.ill = 1'b0;
    if (opc == 7'h33 || opc == 7'h13) begin
      m.a   = src_val(ins[19:15], r1, exw, exr, exv, wbw, wbr, wbv);
      m.sel = tbl[f3];
      if (f3 == 3'd5 && ins[30]) m.sel = 4'd9;
      if (opc == 7'h33 && f3 == 3'd0 && ins[30]) m.sel = 4'd1;
      if (opc == 7'h33) m.b = src_val(ins[24:20], r2, exw, exr, exv, wbw, wbr, wbv);
      else if (f3 == 3'd1 || f3 == 3'd5) m.b = 32'(ins[24:20]);
      else m.b = 32'($signed(ins[31:20]));
      m.wen = (m.rd != 5'd0);
    end else if (opc == 7'h37) begin
      m.a = 32'(ins[31:12]) << 12; m.sel = 4'd15; m.wen = (m.rd != 5'd0);
    end else if (opc == 7'h17) begin
      m.a = p; m.b = 32'(ins[31:12]) << 12; m.wen = (m.rd != 5'd0);
    end else begin
      m.ill = 1'b1;
    end
    return m;
  endfunction

  task automatic drv(input logic iv, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
      input logic exw, input logic [4:0] exr, input logic [31:0] exv,
      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbv,
      input logic fl, input logic ordy);
    logic cap;
    @(posedge clk); #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      if (q.size() == 0) chk("held_pending", 32'd0, 32'd1);
      else cmp_out("held", q[0]);
    end
    if (last_flush) chk("wen_after_flush", {31'd0, reg_wen_q}, 32'd0);
    in_valid = iv; instr = ins; rs1_data = r1; rs2_data = r2;
    pc = $urandom & 32'hFFFF_FFFC;
    ex_wen = exw; ex_rd = exr; ex_result = exv;
    wb_wen = wbw; wb_rd = wbr; wb_result = wbv;
    flush = fl; out_ready = ordy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_valid || ordy)});
    cap = iv && (!exp_valid || ordy);
    if (fl) begin
      if (exp_valid && !ordy) void'(q.pop_front());
      exp_valid = 1'b0;
    end else if (cap) begin
      q.push_back(model(ins, pc, r1, r2, exw, exr, exv, wbw, wbr, wbv));
      exp_valid = 1'b1;
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    last_flush = fl;
  endtask

  task automatic drv_s(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic fl, input logic ordy);
    drv(iv, ins, r1, r2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fl, ordy);
  endtask

  // Monitor: every accepted bundle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon_unexpected: got a bundle, expected none pending");
      end else begin
        cmp_out("mon", q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc;
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    ex_wen = 1'b0; ex_rd = 5'd0; ex_result = 32'd0; wb_wen = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.pc_q", pc_q, 32'd0);
    rst_n = 1'b1;

    drv_s(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b0, 1'b0);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
    drv(1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b1, 5'd1, 32'd100, 1'b1, 5'd1, 32'd9, 1'b0, 1'b1);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("sub_fwd", 32'd100, 32'd7, 4'b0001, 5'd3, 1'b1, 1'b0);
    drv_s(1'b1, 32'h40435293, 32'h11, 32'd0, 1'b0, 1'b1);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("srai", 32'h11, 32'd4, 4'b1001, 5'd5, 1'b1, 1'b0);
    drv(1'b1, 32'hFFF00293, 32'd123, 32'd0, 1'b1, 5'd0, 32'd55, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("addi_x0", 32'd0, 32'hFFFF_FFFF, 4'b0000, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drv_s(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b0, 1'b0);
    expect_out("stall_frozen", 32'd0, 32'hFFFF_FFFF, 4'b0000, 5'd5, 1'b1, 1'b0);
    drv_s(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b0, 1'b1);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    drv_s(1'b1, 32'h123450B7, 32'd0, 32'd0, 1'b1, 1'b1);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    drv_s(1'b1, 32'h123450B7, 32'd0, 32'd0, 1'b0, 1'b0);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("lui", 32'h1234_5000, 32'd0, 4'b1111, 5'd1, 1'b1, 1'b0);
    drv_s(1'b1, 32'h00000FFF, 32'd1, 32'd2, 1'b0, 1'b1);
    drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("illegal", 32'd0, 32'd0, 4'b0000, 5'd31, 1'b0, 1'b1);

    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst.pc_q", pc_q, 32'd0);
    expect_out("midrst", 32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b0);
    q.delete(); exp_valid = 1'b0; last_flush = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: opc = 7'h33;
        1: opc = 7'h13;
        2: opc = 7'h37;
        3: opc = 7'h17;
        default: opc = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h63;
      endcase
      ins = $urandom;
      ins[6:0]   = opc;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      if (opc == 7'h33) ins[24:20] = 5'($urandom_range(0, 3));
      drv(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) drv_s(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("drain.queue_empty", q.size(), 32'd0);
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
